// File: rtl/gate_stim_sequencer.sv
// Steps a 3-input gate operand set {cc,bb,aa} through all eight combinations,
// either on debounced pushbutton presses (manual) or on a fixed dwell timer (auto).
`timescale 1ns/1ps
module gate_stim_sequencer #(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int DWELL_CYC    = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_step,
  input  logic       auto_en,
  output logic       aa,
  output logic       bb,
  output logic       cc,
  output logic [2:0] seq_idx,
  output logic       busy,
  output logic       done
);

  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int DW_W = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYC - 1);

  typedef enum logic [1:0] {IDLE, AUTO, MANUAL, DONE} state_t;

  logic            btn_p0, btn_p1;
  logic            auto_p0, auto_p1;
  logic            btn_db, btn_db_q;
  logic [DB_W-1:0] db_cnt;
  logic            step_p;

  state_t          state, state_n;
  logic [2:0]      idx, idx_n;
  logic [DW_W-1:0] dwell_cnt, dwell_n;
  logic            done_n;

  // Stage p0/p1: two-flop synchronizers for the asynchronous button and switch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_p0  <= 1'b0;
      btn_p1  <= 1'b0;
      auto_p0 <= 1'b0;
      auto_p1 <= 1'b0;
    end else begin
      btn_p0  <= btn_step;
      btn_p1  <= btn_p0;
      auto_p0 <= auto_en;
      auto_p1 <= auto_p0;
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_CYC consecutive differing cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      db_cnt   <= '0;
    end else begin
      btn_db_q <= btn_db;
      if (btn_p1 == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= btn_p1;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  assign step_p = btn_db & ~btn_db_q;

  // Sequencer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 3'd0;
      dwell_cnt <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      dwell_cnt <= dwell_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    dwell_n = dwell_cnt;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        idx_n   = 3'd0;
        dwell_n = '0;
        if (step_p) state_n = auto_p1 ? AUTO : MANUAL;
      end
      MANUAL: begin
        if (step_p) begin
          if (idx == 3'd7) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
      AUTO: begin
        // An abort press takes priority over a coincident terminal count
        if (step_p) begin
          state_n = IDLE;
          idx_n   = 3'd0;
          dwell_n = '0;
        end else if (dwell_cnt == DW_LAST) begin
          dwell_n = '0;
          if (idx == 3'd7) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            idx_n = idx + 3'd1;
          end
        end else begin
          dwell_n = dwell_cnt + DW_W'(1);
        end
      end
      DONE: begin
        if (step_p) begin
          state_n = IDLE;
          idx_n   = 3'd0;
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = 3'd0;
        dwell_n = '0;
      end
    endcase
  end

  assign aa      = idx[0];
  assign bb      = idx[1];
  assign cc      = idx[2];
  assign seq_idx = idx;
  assign busy    = (state == AUTO) || (state == MANUAL);

endmodule

// File: tb/tb_gate_stim_sequencer.sv
// Randomized bench for gate_stim_sequencer compared cycle by cycle against an
// event-level model (press counts and elapsed dwell time) plus directed scenario checks.
`timescale 1ns/1ps
module tb_gate_stim_sequencer;
  localparam int DEBOUNCE_CYC = 4;
  localparam int DWELL_CYC    = 8;
  localparam int M_IDLE = 0, M_MANUAL = 1, M_AUTO = 2, M_FINISHED = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_step = 1'b0;
  logic       auto_en = 1'b0;
  logic       aa, bb, cc, busy, done;
  logic [2:0] seq_idx;

  int checks = 0;
  int errors = 0;

  gate_stim_sequencer #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .DWELL_CYC(DWELL_CYC)) dut (
    .clk(clk), .rst(rst), .btn_step(btn_step), .auto_en(auto_en),
    .aa(aa), .bb(bb), .cc(cc), .seq_idx(seq_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: run mode, number of presses in manual, elapsed cycles in auto
  int         m_mode = M_IDLE;
  int         m_presses = 0;
  int         m_ticks = 0;
  int         m_run = 0;
  logic       m_sb[2];
  logic       m_sa[2];
  logic       m_db = 1'b0;
  logic       m_pend = 1'b0;
  logic [2:0] m_idx = 3'd0;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_mode = M_IDLE; m_presses = 0; m_ticks = 0; m_run = 0;
      m_sb[0] = 1'b0; m_sb[1] = 1'b0; m_sa[0] = 1'b0; m_sa[1] = 1'b0;
      m_db = 1'b0; m_pend = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_pend) begin
        case (m_mode)
          M_IDLE: begin
            m_mode = m_sa[1] ? M_AUTO : M_MANUAL;
            m_presses = 0;
            m_ticks = 0;
          end
          M_MANUAL: begin
            if (m_presses == 7) begin m_mode = M_FINISHED; m_done = 1'b1; end
            else m_presses++;
          end
          default: m_mode = M_IDLE;
        endcase
      end else if (m_mode == M_AUTO) begin
        m_ticks++;
        if (m_ticks == 8 * DWELL_CYC) begin m_mode = M_FINISHED; m_done = 1'b1; end
      end
      m_pend = 1'b0;
      if (m_sb[1] != m_db) m_run++;
      else m_run = 0;
      if (m_run == DEBOUNCE_CYC) begin
        m_db = ~m_db;
        m_run = 0;
        m_pend = m_db;
      end
      m_sb[1] = m_sb[0]; m_sb[0] = btn_step;
      m_sa[1] = m_sa[0]; m_sa[0] = auto_en;
    end
    case (m_mode)
      M_MANUAL: m_idx = 3'(m_presses);
      M_AUTO:   m_idx = 3'(m_ticks / DWELL_CYC);
      M_FINISHED: m_idx = 3'd7;
      default:  m_idx = 3'd0;
    endcase
    m_busy = (m_mode == M_MANUAL) || (m_mode == M_AUTO);
  end

  logic stim_q[$];

  task automatic add_level(input logic v, input int n);
    repeat (n) stim_q.push_back(v);
  endtask

  task automatic add_press(input int hold, input int gap);
    add_level(1'b1, hold);
    add_level(1'b0, gap);
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_step = 1'b0; auto_en = 1'b0;
    #1;
    checks++;
    if ({seq_idx, aa, bb, cc, busy, done} !== 8'd0) begin
      errors++;
      $display("FAIL reset_async got idx=%0d abc=%b%b%b busy=%b done=%b want all 0", seq_idx, aa, bb, cc, busy, done);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({seq_idx, aa, bb, cc, busy, done} !== 8'd0) begin
      errors++;
      $display("FAIL reset_held got idx=%0d abc=%b%b%b busy=%b done=%b want all 0", seq_idx, aa, bb, cc, busy, done);
    end
    rst = 1'b0;
  endtask

  task automatic test_bounce();
    int done_cnt = 0;
    auto_en = 1'b0;
    for (int i = 0; i < 5; i++) begin add_level(1'b1, 2); add_level(1'b0, 2); end
    add_level(1'b1, 12);
    add_level(1'b0, 10);
    while (stim_q.size() > 0) begin
      @(negedge clk);
      checks++;
      if ({seq_idx, aa, bb, cc, busy, done} !== {m_idx, m_idx[0], m_idx[1], m_idx[2], m_busy, m_done}) begin
        errors++;
        $display("FAIL bounce_cycle t=%0t got idx=%0d busy=%b done=%b want idx=%0d busy=%b done=%b", $time, seq_idx, busy, done, m_idx, m_busy, m_done);
      end
      if (done) done_cnt++;
      btn_step = stim_q.pop_front();
    end
    checks++;
    if (busy !== 1'b1 || seq_idx !== 3'd0 || done_cnt !== 0) begin
      errors++;
      $display("FAIL bounce_manual_start got busy=%b idx=%0d dones=%0d want busy=1 idx=0 dones=0", busy, seq_idx, done_cnt);
    end
  endtask

  task automatic test_manual();
    int done_cnt = 0;
    for (int k = 0; k < 8; k++) add_press($urandom_range(5, 9), $urandom_range(5, 9));
    while (stim_q.size() > 0) begin
      @(negedge clk);
      checks++;
      if ({seq_idx, aa, bb, cc, busy, done} !== {m_idx, m_idx[0], m_idx[1], m_idx[2], m_busy, m_done}) begin
        errors++;
        $display("FAIL manual_cycle t=%0t got idx=%0d busy=%b done=%b want idx=%0d busy=%b done=%b", $time, seq_idx, busy, done, m_idx, m_busy, m_done);
      end
      if (done) begin
        done_cnt++;
        checks++;
        if ({aa, bb, cc, busy} !== 4'b1110) begin
          errors++;
          $display("FAIL manual_done_outputs got abc=%b%b%b busy=%b want abc=111 busy=0", aa, bb, cc, busy);
        end
      end
      btn_step = stim_q.pop_front();
    end
    checks++;
    if (done_cnt !== 1 || seq_idx !== 3'd7 || busy !== 1'b0) begin
      errors++;
      $display("FAIL manual_sweep_end got dones=%0d idx=%0d busy=%b want dones=1 idx=7 busy=0", done_cnt, seq_idx, busy);
    end
    add_press(6, 10);
    while (stim_q.size() > 0) begin
      @(negedge clk);
      checks++;
      if ({seq_idx, busy, done} !== {m_idx, m_busy, m_done}) begin
        errors++;
        $display("FAIL manual_ninth_cycle got idx=%0d busy=%b done=%b want idx=%0d busy=%b done=%b", seq_idx, busy, done, m_idx, m_busy, m_done);
      end
      btn_step = stim_q.pop_front();
    end
    checks++;
    if (seq_idx !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL manual_ninth_idle got idx=%0d busy=%b want idx=0 busy=0", seq_idx, busy);
    end
  endtask

  task automatic test_auto();
    int cyc = 0, t1 = -1, t7 = -1, td = -1, done_cnt = 0;
    auto_en = 1'b1;
    add_level(1'b0, 3);
    add_press(6, 90);
    add_press(6, 12);
    while (stim_q.size() > 0) begin
      @(negedge clk);
      cyc++;
      checks++;
      if ({seq_idx, aa, bb, cc, busy, done} !== {m_idx, m_idx[0], m_idx[1], m_idx[2], m_busy, m_done}) begin
        errors++;
        $display("FAIL auto_cycle t=%0t got idx=%0d busy=%b done=%b want idx=%0d busy=%b done=%b", $time, seq_idx, busy, done, m_idx, m_busy, m_done);
      end
      if (seq_idx == 3'd1 && t1 < 0) t1 = cyc;
      if (seq_idx == 3'd7 && t7 < 0) t7 = cyc;
      if (done) begin done_cnt++; if (td < 0) td = cyc; end
      btn_step = stim_q.pop_front();
    end
    checks++;
    if (t7 - t1 !== 6 * DWELL_CYC) begin
      errors++;
      $display("FAIL auto_step_period got %0d cycles from idx 1 to 7 want %0d", t7 - t1, 6 * DWELL_CYC);
    end
    checks++;
    if (td - t7 !== DWELL_CYC || done_cnt !== 1) begin
      errors++;
      $display("FAIL auto_done_timing got delay=%0d dones=%0d want delay=%0d dones=1", td - t7, done_cnt, DWELL_CYC);
    end
    checks++;
    if (seq_idx !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL auto_return_idle got idx=%0d busy=%b want idx=0 busy=0", seq_idx, busy);
    end
  endtask

  task automatic test_abort();
    int done_cnt = 0;
    bit hit = 1'b0;
    auto_en = 1'b1;
    for (int phase = 0; phase < 2; phase++) begin
      add_press(6, 2);
      while (stim_q.size() > 0) begin
        @(negedge clk);
        checks++;
        if ({seq_idx, busy, done} !== {m_idx, m_busy, m_done}) begin
          errors++;
          $display("FAIL abort_start_cycle got idx=%0d busy=%b done=%b want idx=%0d busy=%b done=%b", seq_idx, busy, done, m_idx, m_busy, m_done);
        end
        btn_step = stim_q.pop_front();
      end
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
        @(negedge clk);
        checks++;
        if ({seq_idx, busy, done} !== {m_idx, m_busy, m_done}) begin
          errors++;
          $display("FAIL abort_run_cycle got idx=%0d busy=%b done=%b want idx=%0d busy=%b done=%b", seq_idx, busy, done, m_idx, m_busy, m_done);
        end
        if (done) done_cnt++;
        if (phase == 0) hit = (seq_idx == 3'd3);
        else hit = (m_mode == M_AUTO) && (m_ticks >= 9) && ((m_ticks + 7) % DWELL_CYC == 0);
      end
      checks++;
      if (!hit) begin
        errors++;
        $display("FAIL abort_wait_timeout phase=%0d got idx=%0d want abort point reached", phase, seq_idx);
      end
      btn_step = 1'b1;
      add_level(1'b1, 5);
      add_level(1'b0, 14);
      while (stim_q.size() > 0) begin
        @(negedge clk);
        checks++;
        if ({seq_idx, busy, done} !== {m_idx, m_busy, m_done}) begin
          errors++;
          $display("FAIL abort_cycle phase=%0d got idx=%0d busy=%b done=%b want idx=%0d busy=%b done=%b", phase, seq_idx, busy, done, m_idx, m_busy, m_done);
        end
        if (done) done_cnt++;
        btn_step = stim_q.pop_front();
      end
      checks++;
      if (seq_idx !== 3'd0 || busy !== 1'b0 || done_cnt !== 0) begin
        errors++;
        $display("FAIL abort_idle phase=%0d got idx=%0d busy=%b dones=%0d want idx=0 busy=0 dones=0", phase, seq_idx, busy, done_cnt);
      end
    end
  endtask

  task automatic test_mode_change();
    auto_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      add_press(6, (k == 3) ? 40 : 6);
      while (stim_q.size() > 0) begin
        @(negedge clk);
        checks++;
        if ({seq_idx, busy, done} !== {m_idx, m_busy, m_done}) begin
          errors++;
          $display("FAIL mode_change_cycle got idx=%0d busy=%b done=%b want idx=%0d busy=%b done=%b", seq_idx, busy, done, m_idx, m_busy, m_done);
        end
        btn_step = stim_q.pop_front();
      end
      auto_en = ~auto_en;
    end
    checks++;
    if (seq_idx !== 3'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mode_change_stays_manual got idx=%0d busy=%b want idx=3 busy=1", seq_idx, busy);
    end
    auto_en = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int done_cnt = 0;
    add_press(6, 6);
    add_press(6, 6);
    while (stim_q.size() > 0) begin
      @(negedge clk);
      checks++;
      if ({seq_idx, busy, done} !== {m_idx, m_busy, m_done}) begin
        errors++;
        $display("FAIL midreset_setup_cycle got idx=%0d busy=%b done=%b want idx=%0d busy=%b done=%b", seq_idx, busy, done, m_idx, m_busy, m_done);
      end
      btn_step = stim_q.pop_front();
    end
    checks++;
    if (seq_idx !== 3'd5) begin
      errors++;
      $display("FAIL midreset_setup got idx=%0d want idx=5", seq_idx);
    end
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({seq_idx, aa, bb, cc, busy, done} !== 8'd0) begin
      errors++;
      $display("FAIL midreset_async got idx=%0d abc=%b%b%b busy=%b done=%b want all 0", seq_idx, aa, bb, cc, busy, done);
    end
    #2 rst = 1'b0;
    add_level(1'b0, 20);
    while (stim_q.size() > 0) begin
      @(negedge clk);
      checks++;
      if ({seq_idx, busy, done} !== {m_idx, m_busy, m_done}) begin
        errors++;
        $display("FAIL midreset_after_cycle got idx=%0d busy=%b done=%b want idx=%0d busy=%b done=%b", seq_idx, busy, done, m_idx, m_busy, m_done);
      end
      if (done) done_cnt++;
      btn_step = stim_q.pop_front();
    end
    checks++;
    if (done_cnt !== 0 || busy !== 1'b0 || seq_idx !== 3'd0) begin
      errors++;
      $display("FAIL midreset_discard got dones=%0d busy=%b idx=%0d want dones=0 busy=0 idx=0", done_cnt, busy, seq_idx);
    end
  endtask

  task automatic test_reset_held();
    logic busy_at[16];
    auto_en = 1'b0;
    @(negedge clk);
    btn_step = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      @(negedge clk);
      busy_at[e] = busy;
      checks++;
      if ({seq_idx, busy, done} !== {m_idx, m_busy, m_done}) begin
        errors++;
        $display("FAIL held_cycle e=%0d got idx=%0d busy=%b want idx=%0d busy=%b", e, seq_idx, busy, m_idx, m_busy);
      end
    end
    checks++;
    if (busy_at[2 + DEBOUNCE_CYC] !== 1'b0 || busy_at[3 + DEBOUNCE_CYC] !== 1'b1 || seq_idx !== 3'd0) begin
      errors++;
      $display("FAIL held_step_latency got busy@%0d=%b busy@%0d=%b idx=%0d want 0 1 0", 2 + DEBOUNCE_CYC, busy_at[2 + DEBOUNCE_CYC], 3 + DEBOUNCE_CYC, busy_at[3 + DEBOUNCE_CYC], seq_idx);
    end
    btn_step = 1'b0;
  endtask

  task automatic test_random();
    int run_left = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      checks++;
      if ({seq_idx, aa, bb, cc, busy, done} !== {m_idx, m_idx[0], m_idx[1], m_idx[2], m_busy, m_done}) begin
        errors++;
        $display("FAIL random_cycle c=%0d got idx=%0d abc=%b%b%b busy=%b done=%b want idx=%0d busy=%b done=%b", c, seq_idx, aa, bb, cc, busy, done, m_idx, m_busy, m_done);
      end
      if (run_left == 0) begin
        btn_step = ~btn_step;
        run_left = ($urandom_range(0, 9) == 0) ? $urandom_range(40, 120) : $urandom_range(1, 10);
      end
      run_left--;
      if ($urandom_range(0, 49) == 0) auto_en = ~auto_en;
      rst = ($urandom_range(0, 399) == 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_manual();
    test_auto();
    test_abort();
    test_mode_change();
    test_reset_mid_run();
    test_reset_held();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
